// File: rtl/cond_exec_unit_pkg.sv
// Shared constants for the conditional-execution unit: condition codes,
// NZCV bit positions and the FlagWrite field layout.
package cond_exec_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWrite bit gi controls the flag pair {2*gi+1, 2*gi}.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_exec_unit_cond_check.sv
// Purely combinational decode of a 4-bit condition field against NZCV.
module cond_check
    import cond_exec_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage condition evaluation, NZCV flags register and the
// Execute/Memory pipeline register carrying condition-gated controls.
module cond_exec_unit
    import cond_exec_unit_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    CondE,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagWriteE,
    input  logic          RegWriteE,
    input  logic          MemWriteE,
    input  logic          MemtoRegE,
    input  logic          PCSrcE,
    input  logic          BranchE,
    input  logic [DW-1:0] ALUResultE,
    input  logic [DW-1:0] WriteDataE,
    input  logic [RW-1:0] WA3E,
    input  logic          StallE,
    input  logic          FlushE,
    output logic          CondExE,
    output logic          BranchTakenE,
    output logic [3:0]    Flags,
    output logic          RegWriteM,
    output logic          MemWriteM,
    output logic          MemtoRegM,
    output logic          PCSrcM,
    output logic [DW-1:0] ALUResultM,
    output logic [DW-1:0] WriteDataM,
    output logic [RW-1:0] WA3M
);

    logic [1:0] flag_half_reg [2];
    logic       cond_ex;
    logic       flag_upd;

    // Decode uses the registered flags, so ALUFlags never reaches an output
    // combinationally.
    cond_check u_cond_check (
        .cond    (CondE),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    assign CondExE      = cond_ex;
    assign BranchTakenE = BranchE & cond_ex & ~FlushE & ~StallE;
    assign flag_upd     = ~StallE & ~FlushE & cond_ex;
    assign Flags        = {flag_half_reg[FW_NZ], flag_half_reg[FW_CV]};

    // NZ and CV halves update independently under their own FlagWrite bit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            always_ff @(posedge clk) begin
                if (reset) begin
                    flag_half_reg[gi] <= 2'b00;
                end else if (flag_upd && FlagWriteE[gi]) begin
                    flag_half_reg[gi] <= ALUFlags[2*gi+1 -: 2];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            PCSrcM     <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (!StallE) begin
            if (FlushE) begin
                RegWriteM <= 1'b0;
                MemWriteM <= 1'b0;
                MemtoRegM <= 1'b0;
                PCSrcM    <= 1'b0;
            end else begin
                RegWriteM <= RegWriteE & cond_ex;
                MemWriteM <= MemWriteE & cond_ex;
                MemtoRegM <= MemtoRegE;
                PCSrcM    <= PCSrcE & cond_ex;
            end
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: a driver issues directed instructions
// and queues expectations; a monitor checks combinational and registered outputs.
module tb_cond_exec_unit;

    localparam int DW = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    CondE, ALUFlags;
    logic [1:0]    FlagWriteE;
    logic          RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
    logic [DW-1:0] ALUResultE, WriteDataE;
    logic [RW-1:0] WA3E;
    logic          StallE, FlushE;
    logic          CondExE, BranchTakenE;
    logic [3:0]    Flags;
    logic          RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [DW-1:0] ALUResultM, WriteDataM;
    logic [RW-1:0] WA3M;

    always #5 clk = ~clk;

    cond_exec_unit #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .CondE(CondE), .ALUFlags(ALUFlags),
        .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .BranchE(BranchE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .StallE(StallE), .FlushE(FlushE), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE), .Flags(Flags), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
    );

    typedef struct {
        string         name;
        bit            chk_comb;
        logic          cx, bt;
        logic [3:0]    fl;
        logic          rw, mw, m2r, pcs;
        logic [DW-1:0] alu, wd;
        logic [RW-1:0] wa;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   busy  = 1'b0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: combinational outputs at the negedge while the instruction is
    // presented, registered outputs just after the capturing edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                busy = 1'b1;
                e = exp_q.pop_front();
                if (e.chk_comb) begin
                    cmp(e.name, "CondExE", 32'(CondExE), 32'(e.cx));
                    cmp(e.name, "BranchTakenE", 32'(BranchTakenE), 32'(e.bt));
                end
                @(posedge clk);
                #2;
                cmp(e.name, "Flags", 32'(Flags), 32'(e.fl));
                cmp(e.name, "RegWriteM", 32'(RegWriteM), 32'(e.rw));
                cmp(e.name, "MemWriteM", 32'(MemWriteM), 32'(e.mw));
                cmp(e.name, "MemtoRegM", 32'(MemtoRegM), 32'(e.m2r));
                cmp(e.name, "PCSrcM", 32'(PCSrcM), 32'(e.pcs));
                cmp(e.name, "ALUResultM", ALUResultM, e.alu);
                cmp(e.name, "WriteDataM", WriteDataM, e.wd);
                cmp(e.name, "WA3M", 32'(WA3M), 32'(e.wa));
                $display("txn %-10s flags=%b rw=%b mw=%b m2r=%b pcs=%b alu=%h wa=%h",
                         e.name, Flags, RegWriteM, MemWriteM, MemtoRegM, PCSrcM,
                         ALUResultM, WA3M);
                busy = 1'b0;
            end
        end
    end

    // Drive one instruction (inputs) and queue its expected response.
    task automatic tx(
        input string nm, input logic rst, input logic st, input logic fl,
        input logic [3:0] cond, input logic [3:0] af, input logic [1:0] fw,
        input logic rw, input logic mw, input logic m2r, input logic pcs,
        input logic br, input logic [31:0] alu, input logic [31:0] wd,
        input logic [3:0] wa, input bit cc, input logic ecx, input logic ebt,
        input logic [3:0] efl, input logic erw, input logic emw,
        input logic em2r, input logic epcs, input logic [31:0] ealu,
        input logic [31:0] ewd, input logic [3:0] ewa);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; StallE = st; FlushE = fl; CondE = cond; ALUFlags = af;
        FlagWriteE = fw; RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r;
        PCSrcE = pcs; BranchE = br; ALUResultE = alu; WriteDataE = wd; WA3E = wa;
        e.name = nm; e.chk_comb = cc; e.cx = ecx; e.bt = ebt; e.fl = efl;
        e.rw = erw; e.mw = emw; e.m2r = em2r; e.pcs = epcs;
        e.alu = ealu; e.wd = ewd; e.wa = ewa;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cyc;
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; CondE = 4'b1110;
        ALUFlags = 4'b0000; FlagWriteE = 2'b00; RegWriteE = 1'b0;
        MemWriteE = 1'b0; MemtoRegE = 1'b0; PCSrcE = 1'b0; BranchE = 1'b0;
        ALUResultE = '0; WriteDataE = '0; WA3E = '0;
        repeat (2) @(posedge clk);

        //  name         rst st fl cond     aluf     fw     rw mw m2 pc br alu           wd            wa     cc cx bt  eflags   rw mw m2 pc ealu          ewd           ewa
        tx("rst_tog",    1, 0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 1, 32'hdead0000, 32'hbeef0000, 4'h5, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0);
        tx("rst_stfl",   1, 1, 1, 4'b0001, 4'b1010, 2'b11, 1, 1, 1, 1, 1, 32'h12345678, 32'h9abcdef0, 4'ha, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0);
        tx("subs_z",     0, 0, 0, 4'b1110, 4'b0110, 2'b11, 1, 0, 0, 0, 0, 32'h0,        32'h11,       4'h2, 1, 1, 0, 4'b0110, 1, 0, 0, 0, 32'h0,        32'h11,       4'h2);
        tx("eq_pass",    0, 0, 0, 4'b0000, 4'b1001, 2'b00, 1, 0, 0, 0, 0, 32'h100,      32'h22,       4'h3, 1, 1, 0, 4'b0110, 1, 0, 0, 0, 32'h100,      32'h22,       4'h3);
        tx("ne_fail",    0, 0, 0, 4'b0001, 4'b1111, 2'b11, 0, 1, 0, 0, 1, 32'h200,      32'h33,       4'h4, 1, 0, 0, 4'b0110, 0, 0, 0, 0, 32'h200,      32'h33,       4'h4);
        tx("beq_taken",  0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 32'h300,      32'h44,       4'hf, 1, 1, 1, 4'b0110, 0, 0, 0, 0, 32'h300,      32'h44,       4'hf);
        tx("set_1011",   0, 0, 0, 4'b1110, 4'b1011, 2'b11, 1, 0, 1, 0, 0, 32'h400,      32'h55,       4'h6, 1, 1, 0, 4'b1011, 1, 0, 1, 0, 32'h400,      32'h55,       4'h6);
        tx("ge_partial", 0, 0, 0, 4'b1010, 4'b0100, 2'b10, 0, 1, 0, 0, 0, 32'h500,      32'h66,       4'h7, 1, 1, 0, 4'b0111, 0, 1, 0, 0, 32'h500,      32'h66,       4'h7);
        tx("hi_fail",    0, 0, 0, 4'b1000, 4'b1110, 2'b01, 1, 0, 0, 1, 0, 32'h600,      32'h77,       4'h8, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 32'h600,      32'h77,       4'h8);
        tx("ls_cv",      0, 0, 0, 4'b1001, 4'b0010, 2'b01, 0, 0, 0, 1, 0, 32'h700,      32'h88,       4'h9, 1, 1, 0, 4'b0110, 0, 0, 0, 1, 32'h700,      32'h88,       4'h9);
        tx("nv_resv",    0, 0, 0, 4'b1111, 4'b1111, 2'b11, 1, 1, 0, 1, 1, 32'h800,      32'h99,       4'ha, 1, 0, 0, 4'b0110, 0, 0, 0, 0, 32'h800,      32'h99,       4'ha);
        tx("stall1",     0, 1, 0, 4'b1110, 4'b1000, 2'b11, 1, 0, 0, 0, 1, 32'h900,      32'h9a,       4'hb, 1, 1, 0, 4'b0110, 0, 0, 0, 0, 32'h800,      32'h99,       4'ha);
        tx("stall2",     0, 1, 0, 4'b1110, 4'b1001, 2'b11, 1, 0, 0, 0, 1, 32'ha00,      32'haa,       4'hb, 1, 1, 0, 4'b0110, 0, 0, 0, 0, 32'h800,      32'h99,       4'ha);
        tx("stall3",     0, 1, 0, 4'b1110, 4'b1010, 2'b11, 1, 0, 0, 0, 1, 32'hb00,      32'hbb,       4'hb, 1, 1, 0, 4'b0110, 0, 0, 0, 0, 32'h800,      32'h99,       4'ha);
        tx("release",    0, 0, 0, 4'b1110, 4'b1010, 2'b11, 1, 0, 0, 0, 1, 32'hb00,      32'hbb,       4'hb, 1, 1, 1, 4'b1010, 1, 0, 0, 0, 32'hb00,      32'hbb,       4'hb);
        tx("flush",      0, 0, 1, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 1, 1, 32'hc00,      32'hcc,       4'hc, 1, 1, 0, 4'b1010, 0, 0, 0, 0, 32'hc00,      32'hcc,       4'hc);
        tx("lt_all",     0, 0, 0, 4'b1011, 4'b0000, 2'b00, 1, 1, 1, 1, 0, 32'hd00,      32'hdd,       4'hd, 1, 1, 0, 4'b1010, 1, 1, 1, 1, 32'hd00,      32'hdd,       4'hd);
        tx("stall_fl",   0, 1, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 32'he00,      32'hee,       4'he, 1, 1, 0, 4'b1010, 1, 1, 1, 1, 32'hd00,      32'hdd,       4'hd);
        tx("gt_fail",    0, 0, 0, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 32'hf00,      32'hff,       4'h1, 1, 0, 0, 4'b1010, 0, 0, 0, 0, 32'hf00,      32'hff,       4'h1);
        tx("rst_stall",  1, 1, 0, 4'b1101, 4'b1111, 2'b11, 1, 1, 1, 1, 1, 32'h1234,     32'h5678,     4'h7, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0);
        tx("cc_br",      0, 0, 0, 4'b0011, 4'b1111, 2'b00, 1, 0, 0, 0, 1, 32'h1000,     32'h1,        4'h0, 1, 1, 1, 4'b0000, 1, 0, 0, 0, 32'h1000,     32'h1,        4'h0);
        tx("mi_fail",    0, 0, 0, 4'b0100, 4'b1000, 2'b11, 0, 1, 0, 0, 0, 32'h2000,     32'h2,        4'h1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h2000,     32'h2,        4'h1);

        wait_cyc = 0;
        while ((exp_q.size() > 0 || busy) && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (exp_q.size() > 0 || busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Execute-stage consumer of the ALU result and ALUFlags. It holds the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against it.
- It gates the instruction's side effects (register write, memory write, PC write, flag write) and produces the branch-taken redirect.
- It is also the Execute/Memory pipeline register, carrying the gated control signals and data into the Memory stage.

Parameters:
- DW, 32, datapath width of ALUResultE / WriteDataE
- RW, 4, register-address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- CondE  in  4  condition field of Execute instruction
- ALUFlags  in  4  {N,Z,C,V} from ALU for Execute instruction
- FlagWriteE  in  2  [1]=write N,Z; [0]=write C,V
- RegWriteE  in  1  instruction writes a register
- MemWriteE  in  1  instruction writes memory
- MemtoRegE  in  1  writeback selects memory data
- PCSrcE  in  1  instruction writes PC (non-branch, Rd=R15)
- BranchE  in  1  instruction is a B
- ALUResultE  in  DW  ALU result
- WriteDataE  in  DW  store data
- WA3E  in  RW  destination register
- StallE  in  1  freeze flags and E/M register
- FlushE  in  1  turn Execute instruction into a bubble
- CondExE  out  1  condition passed (combinational)
- BranchTakenE  out  1  redirect fetch (combinational)
- Flags  out  4  current NZCV register
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each  registered gated control
- ALUResultM  out  DW  registered
- WriteDataM  out  DW  registered
- WA3M  out  RW  registered

Behaviour:
- Reset, highest priority: Flags=0000. All M outputs = 0.
- Condition decode uses the registered Flags, not ALUFlags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 reserved, CondExE=0
- BranchTakenE = BranchE & CondExE & ~FlushE & ~StallE. This is combinational, so the redirect is seen in the same cycle.
- Flag update at the edge, when ~StallE & ~FlushE & CondExE:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - The two halves are independent. FlagWriteE=10 leaves C,V unchanged.
- The next instruction sees the updated flags one cycle later. Back-to-back flag-set then conditional instruction is therefore correct with no forwarding.
- E/M register, one-cycle latency:
  - StallE=1: all M outputs and Flags hold. Stall wins over Flush.
  - FlushE=1 (no stall): RegWriteM, MemWriteM, MemtoRegM and PCSrcM load 0. Data fields load their inputs, which are don't-care but deterministic. Flags unchanged.
  - Otherwise:
    - RegWriteM = RegWriteE & CondExE; MemWriteM = MemWriteE & CondExE; PCSrcM = PCSrcE & CondExE.
    - MemtoRegM = MemtoRegE.
    - Data fields and WA3M copy their inputs.
- A failed condition produces a bubble-equivalent in M: no write enables set.
- Reset asserted mid-stall or mid-flush: the reset values apply at the next edge regardless of the other inputs.
- No internal state besides Flags and the E/M register. No combinational path from ALUFlags to any output.

Decomposition:
- Shared package holds:
  - condition-code localparams (COND_EQ … COND_AL, COND_NV)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - the FlagWrite bit positions
- One natural sub-module: cond_check, a purely combinational decode of {CondE, Flags} to CondExE.
- Flags register and E/M register stay in the top.

Test Plan:
- Reset, then hold reset 2 cycles with all inputs toggled -> Flags=0000; all M control=0 throughout.
- SUBS result zero: ALUFlags=0110, FlagWriteE=11, CondE=1110 -> next cycle Flags=0110. A following CondE=0000 with RegWriteE=1 -> CondExE=1, RegWriteM=1.
- Flags=0110, CondE=0001, BranchE=1, MemWriteE=1 -> CondExE=0, BranchTakenE=0, MemWriteM=0, Flags unchanged.
- Partial write: Flags=1011, ALUFlags=0100, FlagWriteE=10 -> Flags=0111.
- StallE=1 for 3 cycles with FlagWriteE=11 and new data each cycle -> Flags and ALUResultM hold their pre-stall values. Release -> the last presented instruction is captured.
- FlushE=1 with RegWriteE=1, PCSrcE=1, CondE=1110, FlagWriteE=11 -> RegWriteM=0, PCSrcM=0, Flags unchanged. StallE=FlushE=1 -> M outputs hold.
